bcast_fanout: RTL and testbench

BCAST_FANOUT -- requirements
Module: bcast_fanout

---
 rtl/bcast_fanout_pkg.sv | 42 ++++
 rtl/bcast_fanout_if.sv | 19 +
 rtl/bcast_child_calc.sv | 51 +++++
 rtl/bcast_fanout.sv | 173 +++++++++++++++++
 tb/tb_bcast_fanout.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bcast_fanout_pkg.sv
// rtl/bcast_fanout_pkg.sv - shared router flit layout, opcodes and fan-out FSM states
package bcast_fanout_pkg;

  // Header sits above the payload; offsets are relative to bit PayloadWidth.
  localparam int HdrWidth         = 50;
  localparam int PayloadWidthDflt = 32;
  localparam int FlitWidth        = HdrWidth + PayloadWidthDflt;

  localparam int TagOff   = 0;
  localparam int TagW     = 17;
  localparam int RankOff  = 17;
  localparam int RankW    = 8;
  localparam int DstOff   = 25;
  localparam int DstW     = 12;
  localparam int SrcOff   = 37;
  localparam int SrcW     = 8;
  localparam int OpOff    = 45;
  localparam int OpW      = 4;
  localparam int ValidOff = 49;

  // dst holds {z, y, x}, each coordinate zero-extended to one nibble
  localparam int CoordW = 4;

  localparam logic [OpW-1:0] OpBcast0 = 4'b0101;
  localparam logic [OpW-1:0] OpBcast1 = 4'b0110;
  localparam logic [OpW-1:0] OpBcast2 = 4'b0111;
  localparam logic [OpW-1:0] OpBcast3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    FAN   = 2'd2
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    , LOCAL = 2'd3
`endif
  } state_t;

  function automatic logic is_bcast(input logic [OpW-1:0] op);
    return (op == OpBcast0) || (op == OpBcast1) || (op == OpBcast2) || (op == OpBcast3);
  endfunction

endpackage

// File: rtl/bcast_fanout_if.sv
// rtl/bcast_fanout_if.sv - flit input/output handshake bundle for the broadcast fan-out
interface bcast_fanout_if #(parameter int FlitWidth = 82);
  logic [FlitWidth-1:0] in_flit;
  logic                 in_valid;
  logic                 in_ready;
  logic [FlitWidth-1:0] out_flit;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );
endinterface

// File: rtl/bcast_child_calc.sv
// rtl/bcast_child_calc.sv - binomial-tree rel/child-rank arithmetic and rank-to-coordinate mapping
module bcast_child_calc
  import bcast_fanout_pkg::*;
#(
  parameter int lg_numprocs = 3,
  parameter int XB          = 1,
  parameter int YB          = 1,
  parameter int ZB          = 1,
  parameter int KW          = 2
) (
  input  logic [lg_numprocs-1:0] own_rank,
  input  logic [lg_numprocs-1:0] root,
  input  logic [KW-1:0]          k,
  output logic                   qual,
  output logic                   more,
  output logic [lg_numprocs-1:0] child_rank,
  output logic [DstW-1:0]        child_dst
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
  , output logic [DstW-1:0]      own_dst
`endif
);

  localparam logic [lg_numprocs-1:0] One = 1;

  logic [lg_numprocs-1:0] rel;
  logic [lg_numprocs-1:0] pow_k;

  function automatic logic [DstW-1:0] to_dst(input logic [lg_numprocs-1:0] r);
    logic [DstW-1:0] d;
    d = '0;
    d[0 +: XB]          = r[0 +: XB];
    d[CoordW +: YB]     = r[XB +: YB];
    d[2*CoordW +: ZB]   = r[XB+YB +: ZB];
    return d;
  endfunction

  // All sums wrap modulo P because they are lg_numprocs bits wide.
  always_comb begin
    rel        = own_rank - root;
    pow_k      = One << k;
    qual       = pow_k > rel;
    more       = (k != '0) && ((One << (k - 1'b1)) > rel);
    child_rank = rel + pow_k + root;
    child_dst  = to_dst(child_rank);
  end

`ifdef BCAST_FANOUT_LOCAL_COPY_EN
  assign own_dst = to_dst(own_rank);
`endif

endmodule

// File: rtl/bcast_fanout.sv
// rtl/bcast_fanout.sv - broadcast flit replicator; BCAST_FANOUT_LOCAL_COPY_EN adds a local copy
module bcast_fanout
  import bcast_fanout_pkg::*;
#(
  parameter logic [2:0] rank_z      = 3'b0,
  parameter logic [2:0] rank_y      = 3'b0,
  parameter logic [2:0] rank_x      = 3'b0,
  parameter int         lg_numprocs = 3,
  parameter int         XB          = 1,
  parameter int         YB          = 1,
  parameter int         ZB          = 1,
  parameter int         PayloadWidth = 32
) (
  input  logic            clk,
  input  logic            rst,
  bcast_fanout_if.slave   bus,
  output logic            done
);

  localparam int FW     = HdrWidth + PayloadWidth;
  localparam int KW     = (lg_numprocs > 1) ? $clog2(lg_numprocs) : 1;
  localparam int LRank  = PayloadWidth + RankOff;
  localparam int LDst   = PayloadWidth + DstOff;
  localparam int LSrc   = PayloadWidth + SrcOff;
  localparam int LOp    = PayloadWidth + OpOff;
  localparam int LValid = PayloadWidth + ValidOff;
  localparam logic [KW-1:0] KTop = KW'(lg_numprocs - 1);

  state_t                 state_q, state_d;
  logic [FW-1:0]          flit_q;
  logic [KW-1:0]          k_q, k_d;
  logic                   done_q, done_d;
  logic                   fin;
  logic                   accept, out_hs;
  logic [lg_numprocs-1:0] own_rank;
  logic [lg_numprocs-1:0] root_sel;
  logic [KW-1:0]          k_sel;
  logic                   qual, more;
  logic [lg_numprocs-1:0] child_rank;
  logic [DstW-1:0]        child_dst;
  logic [RankW-1:0]       rank_ext;
  logic [FW-1:0]          out_flit;
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
  logic [DstW-1:0]        own_dst;
`endif

  assign own_rank = {rank_z[ZB-1:0], rank_y[YB-1:0], rank_x[XB-1:0]};

  // In IDLE the calculator looks at the arriving flit so the leaf decision is made at acceptance.
  assign root_sel = (state_q == IDLE) ? bus.in_flit[LSrc +: lg_numprocs] : flit_q[LSrc +: lg_numprocs];
  assign k_sel    = (state_q == IDLE) ? KTop : k_q;

  bcast_child_calc #(
    .lg_numprocs (lg_numprocs),
    .XB          (XB),
    .YB          (YB),
    .ZB          (ZB),
    .KW          (KW)
  ) u_calc (
    .own_rank   (own_rank),
    .root       (root_sel),
    .k          (k_sel),
    .qual       (qual),
    .more       (more),
    .child_rank (child_rank),
    .child_dst  (child_dst)
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    , .own_dst  (own_dst)
`endif
  );

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q != IDLE) && !rst;
  assign bus.out_flit  = out_flit;
  assign accept        = bus.in_valid && bus.in_ready;
  assign out_hs        = bus.out_valid && bus.out_ready;
  assign done          = (done_q || fin) && !rst;

  always_comb begin
    rank_ext = '0;
    rank_ext[lg_numprocs-1:0] = child_rank;
    out_flit = '0;
    if (!rst) begin
      case (state_q)
        PASS: out_flit = flit_q;
        FAN: begin
          out_flit = flit_q;
          out_flit[LDst +: DstW]   = child_dst;
          out_flit[LRank +: RankW] = rank_ext;
        end
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
        LOCAL: begin
          out_flit = flit_q;
          out_flit[LDst +: DstW] = own_dst;
        end
`endif
        default: out_flit = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!bus.in_flit[LValid]) begin
            done_d = 1'b1;
          end else if (!is_bcast(bus.in_flit[LOp +: OpW])) begin
            state_d = PASS;
          end else if (qual) begin
            state_d = FAN;
            k_d     = KTop;
          end else begin
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
            state_d = LOCAL;
`else
            done_d  = 1'b1;
`endif
          end
        end
      end
      PASS: begin
        if (out_hs) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      FAN: begin
        if (out_hs) begin
          if (more) begin
            k_d = k_q - 1'b1;
          end else begin
            k_d = '0;
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
            state_d = LOCAL;
`else
            fin     = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
      LOCAL: begin
        if (out_hs) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      if (accept) flit_q <= bus.in_flit;
    end
  end

endmodule

// File: tb/tb_bcast_fanout.sv
// tb/tb_bcast_fanout.sv - directed-vector bench for bcast_fanout at ranks 0, 3 and 5
module tb_bcast_fanout;
  import bcast_fanout_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [81:0] drv_flit = '0;
  logic        drv_valid = 1'b0;
  logic        out_rdy = 1'b1;
  int          sel = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  logic [81:0] obs_flit;
  logic        obs_valid, obs_in_ready, obs_done;
  logic        done0, done3, done5;
  logic [81:0] exp_q[$];

  always #5 clk = ~clk;

  bcast_fanout_if #(.FlitWidth(82)) b0();
  bcast_fanout_if #(.FlitWidth(82)) b3();
  bcast_fanout_if #(.FlitWidth(82)) b5();

  assign b0.in_flit = drv_flit;  assign b0.in_valid = drv_valid && (sel == 0);  assign b0.out_ready = out_rdy;
  assign b3.in_flit = drv_flit;  assign b3.in_valid = drv_valid && (sel == 3);  assign b3.out_ready = out_rdy;
  assign b5.in_flit = drv_flit;  assign b5.in_valid = drv_valid && (sel == 5);  assign b5.out_ready = out_rdy;

  bcast_fanout #(.rank_z(3'd0), .rank_y(3'd0), .rank_x(3'd0)) u_r0 (.clk(clk), .rst(rst), .bus(b0), .done(done0));
  bcast_fanout #(.rank_z(3'd0), .rank_y(3'd1), .rank_x(3'd1)) u_r3 (.clk(clk), .rst(rst), .bus(b3), .done(done3));
  bcast_fanout #(.rank_z(3'd1), .rank_y(3'd0), .rank_x(3'd1)) u_r5 (.clk(clk), .rst(rst), .bus(b5), .done(done5));

  always_comb begin
    obs_flit = b0.out_flit; obs_valid = b0.out_valid; obs_in_ready = b0.in_ready; obs_done = done0;
    if (sel == 3) begin
      obs_flit = b3.out_flit; obs_valid = b3.out_valid; obs_in_ready = b3.in_ready; obs_done = done3;
    end else if (sel == 5) begin
      obs_flit = b5.out_flit; obs_valid = b5.out_valid; obs_in_ready = b5.in_ready; obs_done = done5;
    end
  end

  task automatic chk(input string tag, input logic [81:0] obs, input logic [81:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [81:0] mk(input logic v, input logic [3:0] op, input logic [7:0] src,
                                     input logic [11:0] dst, input logic [7:0] rank,
                                     input logic [16:0] tag, input logic [31:0] pl);
    return {v, op, src, dst, rank, tag, pl};
  endfunction

  task automatic send(input logic [81:0] f);
    int w;
    w = 0;
    @(negedge clk);
    drv_flit = f; drv_valid = 1'b1; #1;
    while (!obs_in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    chk("in_ready_before_accept", obs_in_ready, 1);
    @(posedge clk);
  endtask

  // Walks exp_q one output per cycle; stall_idx picks the copy held back for 3 cycles.
  task automatic drain(input int stall_idx);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk); drv_valid = 1'b0; out_rdy = 1'b0; #1;
          chk("stall_valid", obs_valid, 1);
          chk("stall_flit", obs_flit, exp_q[i]);
          chk("stall_in_ready", obs_in_ready, 0);
          chk("stall_done", obs_done, 0);
        end
      end
      @(negedge clk); drv_valid = 1'b0; out_rdy = 1'b1; #1;
      chk("copy_valid", obs_valid, 1);
      chk("copy_flit", obs_flit, exp_q[i]);
      chk("copy_done", obs_done, (i == n - 1) ? 1 : 0);
      chk("copy_in_ready", obs_in_ready, 0);
    end
    @(negedge clk); drv_valid = 1'b0; #1;
    chk("after_valid", obs_valid, 0);
    chk("after_in_ready", obs_in_ready, 1);
    chk("after_done", obs_done, (n == 0) ? 1 : 0);
    exp_q.delete();
  endtask

  logic [81:0] f;

  initial begin
    sel = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", obs_in_ready, 0);
    chk("rst_out_valid", obs_valid, 0);
    chk("rst_done", obs_done, 0);
    chk("rst_out_flit", obs_flit, '0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_in_ready", obs_in_ready, 1);

    // own 0, root 0: children 4, 2, 1
    sel = 0;
    f = mk(1, 4'b0111, 8'd0, 12'hfff, 8'haa, 17'h1abcd, 32'hdeadbeef);
    exp_q.push_back(mk(1, 4'b0111, 8'd0, 12'h100, 8'd4, 17'h1abcd, 32'hdeadbeef));
    exp_q.push_back(mk(1, 4'b0111, 8'd0, 12'h010, 8'd2, 17'h1abcd, 32'hdeadbeef));
    exp_q.push_back(mk(1, 4'b0111, 8'd0, 12'h001, 8'd1, 17'h1abcd, 32'hdeadbeef));
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    exp_q.push_back(mk(1, 4'b0111, 8'd0, 12'h000, 8'haa, 17'h1abcd, 32'hdeadbeef));
`endif
    send(f); drain(-1);

    // own 5, root 1 (rel 4): leaf
    sel = 5;
    f = mk(1, 4'b0110, 8'd1, 12'h222, 8'h11, 17'h00042, 32'h12345678);
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    exp_q.push_back(mk(1, 4'b0110, 8'd1, 12'h101, 8'h11, 17'h00042, 32'h12345678));
`endif
    send(f); drain(-1);

    // own 3, root 2 (rel 1): k=2 -> rank 7, k=1 -> rank 5, k=0 skipped
    sel = 3;
    f = mk(1, 4'b0101, 8'd2, 12'h333, 8'h00, 17'h0f0f0, 32'hcafef00d);
    exp_q.push_back(mk(1, 4'b0101, 8'd2, 12'h111, 8'd7, 17'h0f0f0, 32'hcafef00d));
    exp_q.push_back(mk(1, 4'b0101, 8'd2, 12'h101, 8'd5, 17'h0f0f0, 32'hcafef00d));
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    exp_q.push_back(mk(1, 4'b0101, 8'd2, 12'h011, 8'h00, 17'h0f0f0, 32'hcafef00d));
`endif
    send(f); drain(-1);

    // stall the second copy for 3 cycles, op 1000
    sel = 0;
    f = mk(1, 4'b1000, 8'd0, 12'h000, 8'h55, 17'h15555, 32'h0badcafe);
    exp_q.push_back(mk(1, 4'b1000, 8'd0, 12'h100, 8'd4, 17'h15555, 32'h0badcafe));
    exp_q.push_back(mk(1, 4'b1000, 8'd0, 12'h010, 8'd2, 17'h15555, 32'h0badcafe));
    exp_q.push_back(mk(1, 4'b1000, 8'd0, 12'h001, 8'd1, 17'h15555, 32'h0badcafe));
`ifdef BCAST_FANOUT_LOCAL_COPY_EN
    exp_q.push_back(mk(1, 4'b1000, 8'd0, 12'h000, 8'h55, 17'h15555, 32'h0badcafe));
`endif
    send(f); drain(1);

    // non-broadcast op passes through unchanged
    f = mk(1, 4'b1100, 8'd6, 12'h321, 8'h77, 17'h01234, 32'h89abcdef);
    exp_q.push_back(f);
    send(f); drain(-1);

    // ValidBit = 0 is dropped
    f = mk(0, 4'b0111, 8'd0, 12'h000, 8'h00, 17'h00001, 32'h00000001);
    send(f); drain(-1);

    // reset after the first of three copies
    f = mk(1, 4'b0111, 8'd0, 12'h0aa, 8'h33, 17'h00777, 32'h55aa55aa);
    send(f);
    @(negedge clk); drv_valid = 1'b0; #1;
    chk("mid_first_flit", obs_flit, mk(1, 4'b0111, 8'd0, 12'h100, 8'd4, 17'h00777, 32'h55aa55aa));
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_valid", obs_valid, 0);
    chk("mid_rst_in_ready", obs_in_ready, 0);
    chk("mid_rst_flit", obs_flit, '0);
    rst = 1'b0; #1;
    chk("mid_post_in_ready", obs_in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk("mid_no_more_copies", obs_valid, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
